// File: rtl/fifo_rd_packer.sv
// rtl/fifo_rd_packer.sv - FIFO read-side byte-to-word packer with flush (optional FIFO_PACK_TIMEOUT_EN idle flush)
module fifo_rd_packer #(
    parameter int DW      = 8,
    parameter int N       = 4,
    parameter int TIMEOUT = 16,
    localparam int CW     = $clog2(N + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    input  logic            fifo_empty,
    input  logic [DW-1:0]   fifo_dout,
    output logic            fifo_re,
    input  logic            flush,
    output logic [DW*N-1:0] out_data,
    output logic [N-1:0]    out_be,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [CW-1:0]   fill
);

    logic [DW*N-1:0] acc;
    logic [CW-1:0]   cnt;
    logic            pend;
    logic            fp;
    logic [CW:0]     committed;
    logic            slot_free;
    logic            cnt_zero;
    logic            cnt_full;
    logic            do_xfer;
    logic            fp_done;
    logic            flush_req;
    logic [N-1:0]    be_mask;

    // Lanes already landed plus the one in flight; this bounds the read issue.
    assign committed = {1'b0, cnt} + {{CW{1'b0}}, pend};
    assign fifo_re   = !rst && !clr && !fifo_empty && !fp && (committed < (CW+1)'(N));

    assign slot_free = !out_valid || out_ready;
    assign cnt_zero  = (cnt == '0);
    assign cnt_full  = (cnt == CW'(N));
    assign do_xfer   = slot_free && !cnt_zero && (cnt_full || (fp && !pend));
    assign fp_done   = fp && !pend && (cnt_zero || slot_free);
    assign fill      = cnt;

    always_comb begin
        be_mask = '0;
        for (int k = 0; k < N; k++) begin
            be_mask[k] = (CW'(k) < cnt);
        end
    end

`ifdef FIFO_PACK_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] idle_cnt;
    logic          tmo_hit;

    assign tmo_hit   = (idle_cnt == TW'(TIMEOUT));
    assign flush_req = flush || tmo_hit;

    always_ff @(posedge clk) begin
        if (rst || clr || cnt_zero || pend || fp || !fifo_empty) begin
            idle_cnt <= '0;
        end else if (!tmo_hit) begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end
`else
    assign flush_req = flush;
`endif

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            acc       <= '0;
            cnt       <= '0;
            pend      <= 1'b0;
            fp        <= 1'b0;
            out_data  <= '0;
            out_be    <= '0;
            out_valid <= 1'b0;
        end else begin
            pend <= fifo_re;
            // A landing byte never coincides with a transfer: the issue rule keeps
            // cnt below N while pend is set, and a partial transfer waits for !pend.
            if (do_xfer) begin
                out_data  <= acc;
                out_be    <= be_mask;
                out_valid <= 1'b1;
                acc       <= '0;
                cnt       <= '0;
            end else begin
                if (out_ready) begin
                    out_valid <= 1'b0;
                end
                if (pend) begin
                    acc[int'(cnt)*DW +: DW] <= fifo_dout;
                    cnt                     <= cnt + 1'b1;
                end
            end
            fp <= fp ? !fp_done : flush_req;
        end
    end

endmodule
